// File: rtl/branch_pred_ctrl_pkg.sv
// branch_pred_ctrl_pkg: shared branch encodings, FSM states and BHT constants
package branch_pred_ctrl_pkg;
  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;
  localparam logic [1:0] BHT_INIT = 2'b01;
  typedef enum logic [1:0] {S_INIT, S_RUN, S_RECOVER} state_t;
endpackage

// File: rtl/branch_pred_ctrl_cond.sv
// branch_cond_eval: resolves the branch condition from ALU flags and funct3
module branch_cond_eval
  import branch_pred_ctrl_pkg::*;
(
  input  logic       z,
  input  logic       s,
  input  logic       v,
  input  logic       c,
  input  logic [2:0] funct3,
  output logic       taken
);
  always_comb
    taken = funct3 == BR_BEQ  ? z :
            funct3 == BR_BNE  ? !z :
            funct3 == BR_BLT  ? s != v :
            funct3 == BR_BGE  ? s == v :
            funct3 == BR_BLTU ? !c :
            funct3 == BR_BGEU ? c : 1'b0;
endmodule

// File: rtl/branch_pred_ctrl.sv
// branch_pred_ctrl: 2-bit BHT prediction, EX branch resolution, redirect/flush and stats
module branch_pred_ctrl
  import branch_pred_ctrl_pkg::*;
#(
  parameter int BHT_IDX_W = 6,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic            id_is_branch,
  input  logic [XLEN-1:0] id_pc,
  output logic            pred_taken,
  output logic            id_redirect,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            z,
  input  logic            s,
  input  logic            v,
  input  logic            c,
  input  logic [2:0]      funct3,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            stall,
  output logic [31:0]     br_count,
  output logic [31:0]     mispred_count
);
  localparam int N = 1 << BHT_IDX_W;
  state_t state, state_nx;
  logic [BHT_IDX_W-1:0] init_idx, id_idx, ex_idx;
  logic [1:0] bht [N];
  logic [1:0] ex_cnt;
  logic taken, res, mispred;
  logic unused_id_pc;
  assign id_idx = id_pc[BHT_IDX_W+1:2];
  assign ex_idx = ex_pc[BHT_IDX_W+1:2];
  assign ex_cnt = bht[ex_idx];
  assign unused_id_pc = ^{id_pc[XLEN-1:BHT_IDX_W+2], id_pc[1:0]};
  branch_cond_eval u_cond (
    .z(z), .s(s), .v(v), .c(c), .funct3(funct3), .taken(taken)
  );
  always_ff @(posedge clk)
    state <= rst ? S_INIT : state_nx;
  always_comb begin
    res = ex_valid & ex_is_branch & (state == S_RUN);
    mispred = res & (taken != ex_pred_taken);
    state_nx = state == S_INIT    ? (&init_idx ? S_RUN : S_INIT) :
               state == S_RECOVER ? S_RUN :
               mispred            ? S_RECOVER : S_RUN;
    stall = state == S_INIT;
    pred_taken = !stall & bht[id_idx][1];
    redirect = mispred;
    flush_id_ex = mispred;
    redirect_pc = mispred ? (taken ? ex_target : ex_pc + XLEN'(4)) : '0;
    id_redirect = id_valid & id_is_branch & pred_taken & !mispred;
    flush_if_id = mispred | id_redirect;
  end
  // no bypass: an ID read of the entry being trained sees the old counter
  always_ff @(posedge clk)
    if (state == S_INIT) bht[init_idx] <= BHT_INIT;
    else if (res) bht[ex_idx] <= taken ? (&ex_cnt ? ex_cnt : ex_cnt + 2'd1)
                                       : (|ex_cnt ? ex_cnt - 2'd1 : ex_cnt);
  always_ff @(posedge clk)
    if (rst) begin
      init_idx <= '0;
      br_count <= '0;
      mispred_count <= '0;
    end else begin
      if (state == S_INIT) init_idx <= init_idx + BHT_IDX_W'(1);
      if (res && !(&br_count)) br_count <= br_count + 32'd1;
      if (mispred && !(&mispred_count)) mispred_count <= mispred_count + 32'd1;
    end
endmodule

// File: tb/tb_branch_pred_ctrl.sv
// tb_branch_pred_ctrl: directed vector table plus randomized run against a behavioural model
module tb_branch_pred_ctrl;
  logic clk, rst, id_valid, id_is_branch, pred_taken, id_redirect;
  logic ex_valid, ex_is_branch, ex_pred_taken, z, s, v, c;
  logic [31:0] id_pc, ex_pc, ex_target, redirect_pc, br_count, mispred_count;
  logic [2:0] funct3;
  logic redirect, flush_if_id, flush_id_ex, stall;
  int n_chk = 0, n_err = 0;
  typedef struct {
    logic idv, idb; logic [31:0] idpc;
    logic exv, exb, exp; logic [31:0] pc, tgt;
    logic [3:0] zsvc; logic [2:0] f3; logic r;
  } in_t;
  typedef struct {
    in_t i; logic pred, idr, red; logic [31:0] rpc; logic fif, fie; logic [31:0] br, mp;
  } vec_t;
  branch_pred_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_is_branch(id_is_branch), .id_pc(id_pc),
    .pred_taken(pred_taken), .id_redirect(id_redirect), .ex_valid(ex_valid),
    .ex_is_branch(ex_is_branch), .ex_pred_taken(ex_pred_taken), .ex_pc(ex_pc),
    .ex_target(ex_target), .z(z), .s(s), .v(v), .c(c), .funct3(funct3),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .stall(stall), .br_count(br_count), .mispred_count(mispred_count)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int init_pos = 0;
  bit recov = 0;
  int bht_m [64];
  logic [31:0] br_m = 0, mp_m = 0;
  function automatic bit f_taken();
    case (funct3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return s != v;
      3'd5: return s == v;
      3'd6: return !c;
      3'd7: return c;
      default: return 1'b0;
    endcase
  endfunction
  function automatic bit f_res();
    return init_pos >= 64 && !recov && ex_valid && ex_is_branch;
  endfunction
  function automatic bit f_mis();
    return f_res() && (f_taken() != ex_pred_taken);
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      init_pos = 0; recov = 0; br_m = 0; mp_m = 0;
    end else if (init_pos < 64) begin
      bht_m[init_pos] = 1; init_pos++;
    end else if (recov) recov = 0;
    else if (f_res()) begin
      int k;
      k = int'((ex_pc >> 2) % 64);
      bht_m[k] = f_taken() ? (bht_m[k] < 3 ? bht_m[k] + 1 : 3) : (bht_m[k] > 0 ? bht_m[k] - 1 : 0);
      if (br_m != 32'hFFFF_FFFF) br_m++;
      if (f_mis()) begin
        if (mp_m != 32'hFFFF_FFFF) mp_m++;
        recov = 1;
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic check_model(input string t);
    logic pe, mis, tk, idr;
    mis = f_mis();
    tk = f_taken();
    pe = init_pos >= 64 && bht_m[int'((id_pc >> 2) % 64)] >= 2;
    idr = id_valid && id_is_branch && pe && !mis;
    chk({t, " stall"}, 32'(stall), 32'(init_pos < 64));
    chk({t, " pred_taken"}, 32'(pred_taken), 32'(pe));
    chk({t, " id_redirect"}, 32'(id_redirect), 32'(idr));
    chk({t, " redirect"}, 32'(redirect), 32'(mis));
    chk({t, " redirect_pc"}, redirect_pc, mis ? (tk ? ex_target : ex_pc + 32'd4) : 32'd0);
    chk({t, " flush_if_id"}, 32'(flush_if_id), 32'(mis || idr));
    chk({t, " flush_id_ex"}, 32'(flush_id_ex), 32'(mis));
    chk({t, " br_count"}, br_count, br_m);
    chk({t, " mispred_count"}, mispred_count, mp_m);
  endtask
  task automatic drive(input in_t i);
    id_valid = i.idv; id_is_branch = i.idb; id_pc = i.idpc;
    ex_valid = i.exv; ex_is_branch = i.exb; ex_pred_taken = i.exp;
    ex_pc = i.pc; ex_target = i.tgt; {z, s, v, c} = i.zsvc; funct3 = i.f3; rst = i.r;
  endtask
  function automatic in_t mk(input logic idv, idb, input logic [31:0] idpc, input logic exv, exb, exp,
                             input logic [31:0] pc, tgt, input logic [3:0] zsvc, input logic [2:0] f3,
                             input logic r);
    in_t i;
    i.idv = idv; i.idb = idb; i.idpc = idpc; i.exv = exv; i.exb = exb; i.exp = exp;
    i.pc = pc; i.tgt = tgt; i.zsvc = zsvc; i.f3 = f3; i.r = r;
    return i;
  endfunction
  task automatic wait_init(input string nm);
    int cnt = 0;
    while (stall === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    chk(nm, 32'(cnt), 32'd64);
  endtask
  vec_t tbl [15];
  initial begin
    tbl[0]  = '{mk(1,1,32'h100, 1,1,0, 32'h100, 32'h80, 4'b1000, 3'd0, 0), 0,0,1, 32'h80, 1,1, 0, 0};
    tbl[1]  = '{mk(0,0,32'h100, 1,1,0, 32'h100, 32'h80, 4'b1000, 3'd0, 0), 1,0,0, 32'h0, 0,0, 1, 1};
    tbl[2]  = '{mk(1,1,32'h100, 1,1,1, 32'h200, 32'h300, 4'b0100, 3'd5, 0), 1,0,1, 32'h204, 1,1, 1, 1};
    tbl[3]  = '{mk(0,0,32'h100, 0,0,0, 32'h0, 32'h0, 4'b0000, 3'd0, 0), 0,0,0, 32'h0, 0,0, 2, 2};
    tbl[4]  = '{mk(0,0,32'h100, 1,1,1, 32'h300, 32'h400, 4'b0000, 3'd6, 0), 0,0,0, 32'h0, 0,0, 2, 2};
    tbl[5]  = '{mk(0,0,32'h100, 1,1,1, 32'h340, 32'h500, 4'b1000, 3'd2, 0), 1,0,1, 32'h344, 1,1, 3, 2};
    tbl[6]  = '{mk(1,1,32'h100, 0,0,0, 32'h0, 32'h0, 4'b0000, 3'd0, 0), 1,1,0, 32'h0, 1,0, 4, 3};
    tbl[7]  = '{mk(0,0,32'h14, 1,1,1, 32'h14, 32'h40, 4'b1000, 3'd0, 0), 0,0,0, 32'h0, 0,0, 4, 3};
    tbl[8]  = '{mk(0,0,32'h14, 1,1,1, 32'h14, 32'h40, 4'b1000, 3'd0, 0), 1,0,0, 32'h0, 0,0, 5, 3};
    tbl[9]  = '{mk(0,0,32'h14, 1,1,1, 32'h14, 32'h40, 4'b1000, 3'd0, 0), 1,0,0, 32'h0, 0,0, 6, 3};
    tbl[10] = '{mk(0,0,32'h14, 1,1,1, 32'h14, 32'h40, 4'b1000, 3'd0, 0), 1,0,0, 32'h0, 0,0, 7, 3};
    tbl[11] = '{mk(0,0,32'h14, 1,1,0, 32'h14, 32'h40, 4'b1000, 3'd1, 0), 1,0,0, 32'h0, 0,0, 8, 3};
    tbl[12] = '{mk(0,0,32'h14, 0,0,0, 32'h0, 32'h0, 4'b0000, 3'd0, 0), 1,0,0, 32'h0, 0,0, 9, 3};
    tbl[13] = '{mk(0,0,32'h14, 1,1,1, 32'hFFFF_FFFC, 32'h40, 4'b0000, 3'd0, 0), 1,0,1, 32'h0, 1,1, 9, 3};
    tbl[14] = '{mk(0,0,32'h14, 1,1,0, 32'h14, 32'h40, 4'b1000, 3'd0, 1), 1,0,0, 32'h0, 0,0, 10, 4};
    drive(mk(0,0,32'h100, 0,0,0, 32'h0, 32'h0, 4'b0000, 3'd0, 1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("init pred_taken", 32'(pred_taken), 32'd0);
    chk("init br_count", br_count, 32'd0);
    chk("init mispred_count", mispred_count, 32'd0);
    wait_init("init stall_cycles");
    @(negedge clk);
    for (int k = 0; k < 15; k++) begin
      drive(tbl[k].i);
      #1;
      check_model($sformatf("model%0d", k));
      chk($sformatf("vec%0d pred_taken", k), 32'(pred_taken), 32'(tbl[k].pred));
      chk($sformatf("vec%0d id_redirect", k), 32'(id_redirect), 32'(tbl[k].idr));
      chk($sformatf("vec%0d redirect", k), 32'(redirect), 32'(tbl[k].red));
      chk($sformatf("vec%0d redirect_pc", k), redirect_pc, tbl[k].rpc);
      chk($sformatf("vec%0d flush_if_id", k), 32'(flush_if_id), 32'(tbl[k].fif));
      chk($sformatf("vec%0d flush_id_ex", k), 32'(flush_id_ex), 32'(tbl[k].fie));
      chk($sformatf("vec%0d br_count", k), br_count, tbl[k].br);
      chk($sformatf("vec%0d mispred_count", k), mispred_count, tbl[k].mp);
      @(negedge clk);
    end
    drive(mk(0,0,32'h100, 0,0,0, 32'h0, 32'h0, 4'b0000, 3'd0, 0));
    #1;
    chk("rst_recover stall", 32'(stall), 32'd1);
    chk("rst_recover br_count", br_count, 32'd0);
    wait_init("rst_recover stall_cycles");
    @(negedge clk);
    for (int k = 0; k < 64; k++) begin
      id_pc = 32'(k) << 2;
      #1;
      chk($sformatf("sweep pred%0d", k), 32'(pred_taken), 32'd0);
      @(negedge clk);
    end
    for (int k = 0; k < 3000; k++) begin
      drive(mk(1'($urandom), 1'($urandom), $urandom & 32'hFFFF_003C, ($urandom_range(0, 9) < 7),
               ($urandom_range(0, 9) < 8), 1'($urandom), $urandom & 32'hF000_003C, $urandom,
               4'($urandom), 3'($urandom), ($urandom_range(0, 299) == 0)));
      #1;
      check_model($sformatf("rand%0d", k));
      @(negedge clk);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
